// File: rtl/cdc_pkg.sv
// Shared types and defaults for the clk-to-DAC transmit crossing.
package cdc_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/cdc_sync.sv
// N-stage single-bit flop synchronizer with async reset.
// With RST_VAL=1 and d=0 it doubles as an async-assert / sync-deassert reset.
module cdc_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic aclr,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] r_chain;

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) r_chain <= {STAGES{RST_VAL}};
      else      r_chain <= {r_chain[STAGES-2:0], d};
   end

   assign q = r_chain[STAGES-1];

endmodule

// File: rtl/dac_cdc_tx.sv
// Transmit crossing: small clk-domain FIFO drained one word at a time over a
// 2-phase toggle req/ack handshake into a held dac_clk-domain output register.
//
// state   | meaning
// ST_IDLE | no word in flight; loads tx_reg from FIFO head when non-empty
// ST_WAIT | req != ack_s; tx_reg held until the dac side acknowledges
module dac_cdc_tx
   import cdc_pkg::*;
#(
   parameter int DATA_WIDTH  = 24,
   parameter int ADDR_WIDTH  = 1,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic                  aclr,
   input  logic                  clk,
   input  logic                  wrreq,
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  full,
   output logic                  busy,
   output logic                  ovf,
   input  logic                  dac_clk,
   output logic [DATA_WIDTH-1:0] dac,
   output logic                  dac_valid
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH:0]   r_wptr;
   logic [ADDR_WIDTH:0]   r_rptr;
   logic [ADDR_WIDTH:0]   w_count;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_push;
   logic                  w_pop;

   state_t                r_state;
   logic                  r_req;
   logic [DATA_WIDTH-1:0] r_tx_reg;
   logic                  r_ovf;
   logic                  w_ack_s;

   logic                  w_dac_rst;
   logic                  w_req_s;
   logic                  r_req_hist;
   logic                  r_ack;
   logic [DATA_WIDTH-1:0] r_dac;
   logic                  r_dac_valid;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_count = r_wptr - r_rptr;
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (w_count == (ADDR_WIDTH+1)'(DEPTH));
   assign w_push  = wrreq && !w_full;
   assign w_pop   = (r_state == ST_IDLE) && !w_empty;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[ADDR_WIDTH-1:0]] <= data;
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_push)            r_wptr <= r_wptr + 1'b1;
         if (w_pop)             r_rptr <= r_rptr + 1'b1;
         if (wrreq && w_full)   r_ovf  <= 1'b1;
      end
   end

   // No pop happens in ST_WAIT, which keeps tx_reg stable while req != ack.
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         r_state  <= ST_IDLE;
         r_req    <= 1'b0;
         r_tx_reg <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  r_tx_reg <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
                  r_req    <= ~r_req;
                  r_state  <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (w_ack_s == r_req) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   cdc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ack_sync (
      .clk  (clk),
      .aclr (aclr),
      .d    (r_ack),
      .q    (w_ack_s)
   );

   cdc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_rst_sync (
      .clk  (dac_clk),
      .aclr (aclr),
      .d    (1'b0),
      .q    (w_dac_rst)
   );

   cdc_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_req_sync (
      .clk  (dac_clk),
      .aclr (w_dac_rst),
      .d    (r_req),
      .q    (w_req_s)
   );

   // tx_reg is sampled unsynchronized; it is guaranteed static once req_s toggles.
   always_ff @(posedge dac_clk or posedge w_dac_rst) begin
      if (w_dac_rst) begin
         r_req_hist  <= 1'b0;
         r_ack       <= 1'b0;
         r_dac       <= '0;
         r_dac_valid <= 1'b0;
      end else begin
         r_req_hist <= w_req_s;
         if (w_req_s != r_req_hist) begin
            r_dac       <= r_tx_reg;
            r_dac_valid <= 1'b1;
            r_ack       <= w_req_s;
         end else begin
            r_dac_valid <= 1'b0;
         end
      end
   end

   assign full      = w_full;
   assign busy      = !w_empty || (r_state == ST_WAIT);
   assign ovf       = r_ovf;
   assign dac       = r_dac;
   assign dac_valid = r_dac_valid;

endmodule

// File: tb/tb_dac_cdc_tx.sv
// Self-checking bench for dac_cdc_tx: ordered scoreboard of accepted words
// checked on every dac_clk cycle, plus directed literal expectations.
`timescale 1ns/1ps
module tb_dac_cdc_tx;

   localparam int DW = 24;

   logic          aclr;
   logic          clk;
   logic          wrreq;
   logic [DW-1:0] data;
   logic          full;
   logic          busy;
   logic          ovf;
   logic          dac_clk;
   logic [DW-1:0] dac;
   logic          dac_valid;

   realtime       dac_half = 15.0;
   int            n_checks = 0;
   int            n_err    = 0;
   int            n_valid  = 0;
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] last_dac = '0;

   dac_cdc_tx #(.DATA_WIDTH(DW), .ADDR_WIDTH(1), .SYNC_STAGES(2)) dut (
      .aclr      (aclr),
      .clk       (clk),
      .wrreq     (wrreq),
      .data      (data),
      .full      (full),
      .busy      (busy),
      .ovf       (ovf),
      .dac_clk   (dac_clk),
      .dac       (dac),
      .dac_valid (dac_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      dac_clk = 1'b0;
      forever #(dac_half) dac_clk = ~dac_clk;
   end

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Every dac_clk cycle: a strobe must carry the oldest outstanding word,
   // otherwise the output must hold the last delivered word.
   always @(negedge dac_clk) begin
      if (aclr) begin
         last_dac = '0;
      end else if (dac_valid) begin
         n_valid++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL dac_spurious: got dac_valid with 0x%0h, expected no word", dac);
         end else begin
            check("dac_word", 32'(dac), 32'(exp_q[0]));
            last_dac = exp_q.pop_front();
         end
      end else begin
         check("dac_hold", 32'(dac), 32'(last_dac));
      end
   end

   task automatic drive(input logic w, input logic [DW-1:0] d);
      @(negedge clk);
      wrreq = w;
      data  = d;
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while ((busy || exp_q.size() != 0) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(k < 3000), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      wrreq = 1'b0;
      aclr  = 1'b1;
      exp_q.delete();
      repeat (3) @(negedge clk);
      aclr = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   task automatic random_run(input realtime half, input string name);
      int acc  = 0;
      int iter = 0;
      dac_half = half;
      repeat (20) @(negedge clk);
      while (acc < 200 && iter < 20000) begin
         @(negedge clk);
         iter++;
         if ($urandom_range(0, 1) == 1 && !full) begin
            wrreq = 1'b1;
            data  = DW'($urandom);
            exp_q.push_back(data);
            acc++;
         end else begin
            wrreq = 1'b0;
         end
      end
      @(negedge clk);
      wrreq = 1'b0;
      wait_idle({name, "_drain"});
      check({name, "_count"}, 32'(acc), 32'd200);
      check({name, "_ovf"}, 32'(ovf), 32'd0);
   endtask

   initial begin
      int v0;
      aclr  = 1'b0;
      wrreq = 1'b0;
      data  = '0;
      #1 aclr = 1'b1;
      #2;
      check("rst_full", 32'(full), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_dac", 32'(dac), 32'd0);
      check("rst_dac_valid", 32'(dac_valid), 32'd0);
      repeat (3) @(negedge clk);
      aclr = 1'b0;
      repeat (20) @(negedge clk);

      // single word, dac_clk = clk/3
      v0 = n_valid;
      drive(1'b1, 24'hA5A5A5);
      exp_q.push_back(24'hA5A5A5);
      drive(1'b0, '0);
      wait_idle("single_drain");
      repeat (10) @(negedge clk);
      check("single_nvalid", 32'(n_valid - v0), 32'd1);
      check("single_dac", 32'(dac), 32'hA5A5A5);
      check("single_busy", 32'(busy), 32'd0);
      check("single_ovf", 32'(ovf), 32'd0);

      // burst ordering, two back-to-back pairs
      v0 = n_valid;
      for (int r = 0; r < 2; r++) begin
         drive(1'b1, 24'h000001);
         exp_q.push_back(24'h000001);
         drive(1'b1, 24'h000002);
         exp_q.push_back(24'h000002);
         drive(1'b0, '0);
         wait_idle("burst_drain");
      end
      check("burst_nvalid", 32'(n_valid - v0), 32'd4);
      check("burst_dac", 32'(dac), 32'h000002);

      // push and pop on the same edge: count stays at one
      v0 = n_valid;
      drive(1'b1, 24'h000077);
      exp_q.push_back(24'h000077);
      drive(1'b1, 24'h000088);
      exp_q.push_back(24'h000088);
      drive(1'b0, '0);
      check("pushpop_full", 32'(full), 32'd0);
      check("pushpop_busy", 32'(busy), 32'd1);
      wait_idle("pushpop_drain");
      check("pushpop_nvalid", 32'(n_valid - v0), 32'd2);
      check("pushpop_dac", 32'(dac), 32'h000088);

      // overflow with slow dac_clk: one in flight, two buffered, fourth dropped
      dac_half = 35.0;
      repeat (20) @(negedge clk);
      v0 = n_valid;
      drive(1'b1, 24'h000011);
      exp_q.push_back(24'h000011);
      drive(1'b1, 24'h000022);
      exp_q.push_back(24'h000022);
      drive(1'b1, 24'h000033);
      exp_q.push_back(24'h000033);
      drive(1'b1, 24'h000044);
      check("ovf_full", 32'(full), 32'd1);
      check("ovf_before_drop", 32'(ovf), 32'd0);
      drive(1'b0, '0);
      check("ovf_set", 32'(ovf), 32'd1);
      wait_idle("ovf_drain");
      repeat (10) @(negedge clk);
      check("ovf_sticky", 32'(ovf), 32'd1);
      check("ovf_nvalid", 32'(n_valid - v0), 32'd3);
      check("ovf_dac", 32'(dac), 32'h000033);

      // reset while a word is in flight
      dac_half = 15.0;
      do_reset();
      check("rst2_ovf", 32'(ovf), 32'd0);
      drive(1'b1, 24'h000055);
      drive(1'b0, '0);
      drive(1'b0, '0);
      check("midrst_busy", 32'(busy), 32'd1);
      aclr = 1'b1;
      #2;
      check("midrst_dac", 32'(dac), 32'd0);
      check("midrst_busy_clr", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      aclr = 1'b0;
      v0 = n_valid;
      repeat (40) @(negedge clk);
      check("midrst_nvalid", 32'(n_valid - v0), 32'd0);
      check("midrst_dac_after", 32'(dac), 32'd0);
      drive(1'b1, 24'h000066);
      exp_q.push_back(24'h000066);
      drive(1'b0, '0);
      wait_idle("midrst_drain");
      check("midrst_next_nvalid", 32'(n_valid - v0), 32'd1);
      check("midrst_next_dac", 32'(dac), 32'h000066);

      // random traffic, fast then slow dac_clk
      random_run(10.0 / 2.3 / 2.0, "rand_fast");
      random_run(25.0, "rand_slow");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
